and_bf_gate: RTL and testbench
==============================

# and_bf_gate

Behavioural-flow two-input AND gate (`and_bf`) with a clocked observation wrapper. The primary output `y` is the pure combinational AND of `a` and `b`. A registered copy, a high-cycle counter and an input-combination coverage mask are added for use in logic-gate demo and self-check benches. The block is a leaf cell instantiated directly by gate-level test harnesses.

## Interface
Parameters:
- `WIDTH`, default 1: bit width of `a`, `b`, `y`, `y_q`.
- `CNT_W`, default 16: width of `high_cnt`.

Ports:
- `clk`, input, 1: rising-edge clock. Used only by the observation logic.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `y`, output, WIDTH: combinational `a & b`.
- `a`, input, WIDTH: operand A.
- `b`, input, WIDTH: operand B.
- `clr`, input, 1: synchronous clear of `high_cnt` and `seen`.
- `y_q`, output, WIDTH: `y` registered once.
- `high_cnt`, output, CNT_W: saturating count of sampled cycles with `y != 0`.
- `seen`, output, 4: coverage mask of sampled `{a[0],b[0]}` combinations.

Declaration order is fixed as `y, a, b, clk, rst_n, clr, y_q, high_cnt, seen`, so positional instantiation `and_bf(y,a,b)` is legal. Unconnected `clk`/`rst_n`/`clr` must not affect `y`.

## Operation
- `y` is a continuous bitwise AND, computed in a behavioural `always @*` block.
  - No state. No dependence on `clk`, `rst_n` or `clr`.
  - X/Z handling follows Verilog `&` semantics: 0 dominates.
- `y_q` is loaded with `a & b` on every rising `clk`.
- `high_cnt` increments by 1 on each rising edge where `(a & b) != 0`.
  - It saturates at all-ones and never wraps.
- `seen[{a[0],b[0]}]` is set to 1 on each rising edge.
  - Bits are sticky until reset or `clr`.
  - Bit 0 = 00, bit 1 = 01, bit 2 = 10, bit 3 = 11.
- `clr` (sampled high at an edge) sets `high_cnt` to 0 and `seen` to 0 that cycle.
  - `clr` takes priority over increment and set in the same cycle.
  - `y_q` still updates normally.
- Reset (`rst_n` = 0) immediately forces `y_q` = 0, `high_cnt` = 0 and `seen` = 0.
  - Reset does not affect `y`.

## Timing
- `y`: zero-cycle latency, combinational only. It changes in the same delta as `a`/`b`.
- `y_q`, `high_cnt`, `seen`: one-cycle latency from the input sampled at the rising edge.
- Asynchronous assert of `rst_n` clears registered outputs without a clock edge.
- On deassert, the first update occurs at the first rising edge with `rst_n` = 1.
- Reset asserted mid-count discards all accumulated state.
- Saturation: at `high_cnt` = 2^CNT_W−1 with `y != 0`, the count holds.

## Structure
- No shared package is needed. Combination-index constants (`COMB_00`..`COMB_11`) may live in a small `logic_gates_pkg` if other gate cells reuse them.
- Natural sub-module: `and_bf_obs`, holding the registered copy, counter and coverage logic. The combinational AND stays in the top.

## Test plan
- Unclocked sweep: `{a,b}` = 00 at 0 ns, 01 at 10 ns, 10 at 30 ns, 11 at 70 ns; end at 130 ns. Required: `y` = 0, 0, 0, 1, with no clock connected.
- Clocked sweep of all four combinations, one per cycle after reset. Required: `y_q` lags `y` by one cycle; `seen` reaches 4'b1111; `high_cnt` = 1.
- Hold `a` = `b` = 1 for 5 cycles, then `clr` for 1 cycle. Required: `high_cnt` = 5, then 0; `seen` = 0 after the clr edge.
- With CNT_W = 2 and `y` = 1 for 6 cycles, required: `high_cnt` saturates at 3.
- Assert `rst_n` low mid-sequence between clock edges. Required: `y_q`, `high_cnt` and `seen` are 0 immediately; `y` still equals `a & b`.
- With WIDTH = 4, `a` = 4'b1100 and `b` = 4'b1010, required: `y` = 4'b1000 and `seen[0]` set.

Source files
------------

// File: rtl/and_bf_gate_pkg.sv
// Shared constants for the logic-gate demo cells.
// Names the four {a[0],b[0]} input combinations used by the coverage mask.
// Also provides a helper that maps operand LSBs onto a combination index.
package and_bf_gate_pkg;

  localparam int N_COMB = 4;

  localparam logic [1:0] COMB_00 = 2'd0;
  localparam logic [1:0] COMB_01 = 2'd1;
  localparam logic [1:0] COMB_10 = 2'd2;
  localparam logic [1:0] COMB_11 = 2'd3;

  // Operand A is the high bit of the index, operand B the low bit.
  function automatic logic [1:0] comb_idx(input logic a0, input logic b0);
    return {a0, b0};
  endfunction

endpackage

// File: rtl/and_bf_gate_obs.sv
// Observation logic for and_bf_gate: registered copy, saturating high counter, coverage mask.
// Latency: one cycle from the sampled rising edge; asynchronous active-low reset.
// No backpressure: samples its inputs on every clock edge.
module and_bf_gate_obs
  import and_bf_gate_pkg::*;
#(
  parameter int WIDTH = 1,
  parameter int CNT_W = 16
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_clr,
  input  logic [WIDTH-1:0]  i_y,
  input  logic [1:0]        i_sel,
  output logic [WIDTH-1:0]  o_y_q,
  output logic [CNT_W-1:0]  o_high_cnt,
  output logic [N_COMB-1:0] o_seen
);

  logic [WIDTH-1:0]  r_y_q;
  logic [CNT_W-1:0]  r_high_cnt;
  logic [N_COMB-1:0] r_seen;

  logic              w_hit;
  logic              w_sat;
  logic [N_COMB-1:0] w_seen_set;

  assign w_hit = |i_y;
  assign w_sat = &r_high_cnt;

  // Decode the sampled combination into a one-hot set mask; unknown index sets nothing.
  always_comb begin
    w_seen_set = '0;
    case (i_sel)
      COMB_00: w_seen_set = 4'b0001;
      COMB_01: w_seen_set = 4'b0010;
      COMB_10: w_seen_set = 4'b0100;
      COMB_11: w_seen_set = 4'b1000;
      default: w_seen_set = '0;
    endcase
  end

  // Registered copy of the AND result; clr does not touch it.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_y_q <= '0;
    end else begin
      r_y_q <= i_y;
    end
  end

  // Count edges with a non-zero result, holding at all-ones; clr wins over increment.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_high_cnt <= '0;
    end else if (i_clr) begin
      r_high_cnt <= '0;
    end else if (w_hit && !w_sat) begin
      r_high_cnt <= r_high_cnt + CNT_W'(1);
    end
  end

  // Sticky coverage of observed LSB combinations; clr wins over set.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_seen <= '0;
    end else if (i_clr) begin
      r_seen <= '0;
    end else begin
      r_seen <= r_seen | w_seen_set;
    end
  end

  assign o_y_q      = r_y_q;
  assign o_high_cnt = r_high_cnt;
  assign o_seen     = r_seen;

endmodule

// File: rtl/and_bf_gate.sv
// Behavioural two-input AND gate with a clocked observation wrapper.
// Latency: y is combinational (zero cycles); y_q/high_cnt/seen one cycle.
// No backpressure; y never depends on clk, rst_n or clr so and_bf(y,a,b) works unclocked.
module and_bf_gate
  import and_bf_gate_pkg::*;
#(
  parameter int WIDTH = 1,
  parameter int CNT_W = 16
) (
  output logic [WIDTH-1:0]  y,
  input  logic [WIDTH-1:0]  a,
  input  logic [WIDTH-1:0]  b,
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  output logic [WIDTH-1:0]  y_q,
  output logic [CNT_W-1:0]  high_cnt,
  output logic [N_COMB-1:0] seen
);

  logic [1:0] w_sel;

  // Pure bitwise AND; X/Z resolve with the usual 0-dominant semantics.
  always @* begin
    y = a & b;
  end

  assign w_sel = comb_idx(a[0], b[0]);

  and_bf_gate_obs #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_obs (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_clr      (clr),
    .i_y        (y),
    .i_sel      (w_sel),
    .o_y_q      (y_q),
    .o_high_cnt (high_cnt),
    .o_seen     (seen)
  );

endmodule

// File: tb/tb_and_bf_gate.sv
// Self-checking bench for and_bf_gate: unclocked sweep, clocked sweep, clr, saturation, async reset.
// Three instances: default widths, CNT_W=2 for saturation, WIDTH=4 for the wide operand case.
module tb_and_bf_gate;

  logic        clk = 1'b0;
  logic        clk_en = 1'b0;
  logic        rst_n = 1'b1;
  logic        clr = 1'b0;
  logic        a = 1'b0;
  logic        b = 1'b0;
  logic        y, y_q;
  logic [15:0] high_cnt;
  logic [3:0]  seen;

  logic        y_s, y_q_s;
  logic [1:0]  cnt_s;
  logic [3:0]  seen_s;

  logic [3:0]  a4 = 4'b1100;
  logic [3:0]  b4 = 4'b1010;
  logic [3:0]  y4, y_q4;
  logic [15:0] high_cnt4;
  logic [3:0]  seen4;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic a;
    logic b;
    logic clr;
    logic exp_y;
  } vec_t;

  typedef struct {
    logic        y_q;
    logic [15:0] cnt;
    logic [1:0]  cnt2;
    logic [3:0]  seen;
  } exp_t;

  exp_t sb[$];

  logic        m_yq;
  logic [15:0] m_cnt;
  logic [1:0]  m_cnt2;
  logic [3:0]  m_seen;

  and_bf_gate #(.WIDTH(1), .CNT_W(16)) dut (
    .y(y), .a(a), .b(b), .clk(clk), .rst_n(rst_n), .clr(clr),
    .y_q(y_q), .high_cnt(high_cnt), .seen(seen)
  );

  and_bf_gate #(.WIDTH(1), .CNT_W(2)) dut_s (
    .y(y_s), .a(a), .b(b), .clk(clk), .rst_n(rst_n), .clr(clr),
    .y_q(y_q_s), .high_cnt(cnt_s), .seen(seen_s)
  );

  and_bf_gate #(.WIDTH(4), .CNT_W(16)) dut_w (
    .y(y4), .a(a4), .b(b4), .clk(clk), .rst_n(rst_n), .clr(clr),
    .y_q(y_q4), .high_cnt(high_cnt4), .seen(seen4)
  );

  initial forever begin
    #5;
    if (clk_en) clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_yq = 1'b0; m_cnt = '0; m_cnt2 = '0; m_seen = '0;
    sb.delete();
  endtask

  // Drive inputs and push the expected registered state after the next rising edge.
  task automatic drive(input logic ia, input logic ib, input logic iclr);
    exp_t e;
    a = ia; b = ib; clr = iclr;
    if (iclr) begin
      m_cnt = '0; m_cnt2 = '0; m_seen = '0;
    end else begin
      if ((ia & ib) && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
      if ((ia & ib) && m_cnt2 != 2'd3) m_cnt2 = m_cnt2 + 2'd1;
      m_seen[{ia, ib}] = 1'b1;
    end
    m_yq = ia & ib;
    e.y_q = m_yq; e.cnt = m_cnt; e.cnt2 = m_cnt2; e.seen = m_seen;
    sb.push_back(e);
  endtask

  task automatic check_sb();
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("y_q",      32'(y_q),      32'(e.y_q));
      chk("high_cnt", 32'(high_cnt), 32'(e.cnt));
      chk("seen",     32'(seen),     32'(e.seen));
      chk("sat_cnt",  32'(cnt_s),    32'(e.cnt2));
      chk("sat_seen", 32'(seen_s),   32'(e.seen));
      chk("sat_y_q",  32'(y_q_s),    32'(e.y_q));
    end
  endtask

  // One cycle at the falling edge: compare last result, drive new inputs, check comb y.
  task automatic cycle(input logic ia, input logic ib, input logic iclr, input logic ey);
    @(negedge clk);
    check_sb();
    drive(ia, ib, iclr);
    #1;
    chk("y", 32'(y), 32'(ey));
  endtask

  vec_t vecs[4];

  initial begin
    vecs[0] = '{a: 1'b0, b: 1'b0, clr: 1'b0, exp_y: 1'b0};
    vecs[1] = '{a: 1'b0, b: 1'b1, clr: 1'b0, exp_y: 1'b0};
    vecs[2] = '{a: 1'b1, b: 1'b0, clr: 1'b0, exp_y: 1'b0};
    vecs[3] = '{a: 1'b1, b: 1'b1, clr: 1'b0, exp_y: 1'b1};
    model_reset();

    // Unclocked sweep with reset held; registered outputs must be cleared.
    a = 1'b0; b = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    chk("unclk_y00",   32'(y),         32'd0);
    chk("wide_y",      32'(y4),        32'h8);
    chk("rst_y_q",     32'(y_q),       32'd0);
    chk("rst_cnt",     32'(high_cnt),  32'd0);
    chk("rst_seen",    32'(seen),      32'd0);
    chk("rst_cnt_s",   32'(cnt_s),     32'd0);
    chk("rst_cnt4",    32'(high_cnt4), 32'd0);
    #8  a = 1'b0; b = 1'b1;
    #1  chk("unclk_y01", 32'(y), 32'd0);
    #19 a = 1'b1; b = 1'b0;
    #1  chk("unclk_y10", 32'(y), 32'd0);
    #39 a = 1'b1; b = 1'b1;
    #1  chk("unclk_y11", 32'(y), 32'd1);
    chk("unclk_y_s", 32'(y_s), 32'd1);
    #59 a = 1'b0; b = 1'b0;

    // Start the clock and release reset between edges.
    clk_en = 1'b1;
    @(posedge clk);
    #2 rst_n = 1'b1;
    model_reset();

    // Clocked sweep of all four combinations.
    for (int i = 0; i < 4; i++) cycle(vecs[i].a, vecs[i].b, vecs[i].clr, vecs[i].exp_y);
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
    chk("sweep_seen", 32'(seen),     32'hF);
    chk("sweep_cnt",  32'(high_cnt), 32'd1);

    // Clear, hold 11 for five cycles, then clr with inputs still high.
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b1, 1'b0, 1'b1);
    cycle(1'b1, 1'b1, 1'b1, 1'b1);
    chk("hold_cnt5", 32'(high_cnt), 32'd5);
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
    chk("clr_cnt",  32'(high_cnt), 32'd0);
    chk("clr_seen", 32'(seen),     32'd0);
    chk("clr_y_q",  32'(y_q),      32'd1);

    // Six high cycles: the 2-bit counter must hold at 3.
    for (int i = 0; i < 6; i++) cycle(1'b1, 1'b1, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
    chk("sat_hold3", 32'(cnt_s),    32'd3);
    chk("cnt_six",   32'(high_cnt), 32'd6);

    // Asynchronous reset between edges clears registers at once; y keeps following a & b.
    #2;
    a = 1'b1; b = 1'b1;
    rst_n = 1'b0;
    #1;
    chk("arst_y_q",  32'(y_q),      32'd0);
    chk("arst_cnt",  32'(high_cnt), 32'd0);
    chk("arst_seen", 32'(seen),     32'd0);
    chk("arst_cnt_s", 32'(cnt_s),   32'd0);
    chk("arst_y",    32'(y),        32'd1);
    model_reset();
    @(posedge clk);
    #2 rst_n = 1'b1;

    cycle(1'b1, 1'b1, 1'b0, 1'b1);
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    check_sb();
    chk("wide_seen0", 32'(seen4[0]), 32'd1);
    chk("wide_y_q",   32'(y_q4),     32'h8);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
